// File: rtl/aes_128_sched.sv
// aes_128_sched: round-robin front end that shares one non-stallable aes_128
// pipeline between two requesters. Every issue reserves an output FIFO slot
// up front (credits) so results returning from the pipeline always have room.
module aes_128_sched #(
  parameter int unsigned LATENCY    = 21,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_state,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_state,
  input  logic [127:0] req1_key,
  output logic [127:0] aes_state,
  output logic [127:0] aes_key,
  input  logic [127:0] aes_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_id,
  output logic         busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = 128;

  // Issue path registers
  logic [DW-1:0]      r_aes_state;
  logic [DW-1:0]      r_aes_key;
  logic               r_rr;

  // In-flight tracking: one valid/ID pair per pipeline stage
  logic [LATENCY-1:0] r_sr_vld;
  logic [LATENCY-1:0] r_sr_id;

  // Output FIFO with extra wrap bit on the pointers
  logic [DW-1:0]      r_mem_data [FIFO_DEPTH];
  logic               r_mem_id   [FIFO_DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic               r_rsp_valid;

  // Credits = jobs in flight + FIFO occupancy
  logic [PW-1:0]      r_credits;
  logic               r_busy;

  logic               w_pop;
  logic               w_can_issue;
  logic               w_win0;
  logic               w_win1;
  logic               w_issue;
  logic               w_issue_id;
  logic               w_capture;
  logic               w_cap_id;
  logic               w_full;
  logic [PW-1:0]      w_wr_nxt;
  logic [PW-1:0]      w_rd_nxt;
  logic [PW-1:0]      w_credits_nxt;
  logic [DW-1:0]      w_issue_state;
  logic [DW-1:0]      w_issue_key;

  assign w_pop       = r_rsp_valid && rsp_ready;
  assign w_can_issue = (r_credits < PW'(FIFO_DEPTH)) || w_pop;

  // A lone requester always wins; with both valid the RR pointer decides
  assign w_win1 = req1_valid && (!req0_valid || r_rr);
  assign w_win0 = req0_valid && !w_win1;

  assign req0_ready = w_win0 && w_can_issue;
  assign req1_ready = w_win1 && w_can_issue;

  assign w_issue    = req0_ready || req1_ready;
  assign w_issue_id = req1_ready;

  assign w_capture  = r_sr_vld[LATENCY-1];
  assign w_cap_id   = r_sr_id[LATENCY-1];

  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_nxt = r_wr_ptr + PW'(w_capture);
  assign w_rd_nxt = r_rd_ptr + PW'(w_pop);

  // Select the winning requester's payload and next credit count
  always_comb begin
    w_issue_state = req0_state;
    w_issue_key   = req0_key;
    w_credits_nxt = r_credits;
    if (w_issue_id) begin
      w_issue_state = req1_state;
      w_issue_key   = req1_key;
    end
    if (w_issue && !w_pop) begin
      w_credits_nxt = r_credits + PW'(1);
    end else if (!w_issue && w_pop) begin
      w_credits_nxt = r_credits - PW'(1);
    end
  end

  // Issue registers, arbitration pointer, in-flight shift register, FIFO control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aes_state <= '0;
      r_aes_key   <= '0;
      r_rr        <= 1'b0;
      r_sr_vld    <= '0;
      r_sr_id     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rsp_valid <= 1'b0;
      r_credits   <= '0;
      r_busy      <= 1'b0;
    end else begin
      if (w_issue) begin
        r_aes_state <= w_issue_state;
        r_aes_key   <= w_issue_key;
        r_rr        <= ~w_issue_id;
      end
      r_sr_vld    <= {r_sr_vld[LATENCY-2:0], w_issue};
      r_sr_id     <= {r_sr_id[LATENCY-2:0], w_issue_id};
      r_wr_ptr    <= w_wr_nxt;
      r_rd_ptr    <= w_rd_nxt;
      r_rsp_valid <= (w_wr_nxt != w_rd_nxt);
      r_credits   <= w_credits_nxt;
      r_busy      <= (w_credits_nxt != '0);
    end
  end

  // FIFO storage; a full-FIFO write only happens alongside a pop of the same slot
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem_data[r_wr_ptr[AW-1:0]] <= aes_out;
      r_mem_id[r_wr_ptr[AW-1:0]]   <= w_cap_id;
    end
  end

  // Credits guarantee a free slot for every capture
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_capture && w_full && !w_pop));

  assign aes_state = r_aes_state;
  assign aes_key   = r_aes_key;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_mem_data[r_rd_ptr[AW-1:0]];
  assign rsp_id    = r_mem_id[r_rd_ptr[AW-1:0]];
  assign busy      = r_busy;

endmodule

// File: tb/tb_aes_128_sched.sv
// Bench for aes_128_sched: a software AES-128 stands in for the aes_128
// pipeline; issued jobs feed an expected-response queue that a separate
// monitor drains whenever the DUT hands out a response.
module tb_aes_128_sched;

  localparam int unsigned LAT   = 21;
  localparam int unsigned DEPTH = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_state, req0_key, req1_state, req1_key;
  logic [127:0] aes_state, aes_key, aes_out;
  logic         rsp_valid, rsp_ready, rsp_id, busy;
  logic [127:0] rsp_data;

  typedef struct packed {
    logic [127:0] data;
    logic         id;
  } exp_t;

  exp_t         exp_q[$];
  int           glog[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           n_issued = 0;
  int           cyc = 0;
  logic [7:0]   sbox [256];
  logic [127:0] pipe [LAT-1];

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_128_sched #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_state(req0_state), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_state(req1_state), .req1_key(req1_key),
    .aes_state(aes_state), .aes_key(aes_key), .aes_out(aes_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- software AES-128 ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  initial begin
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv;
      logic [7:0] xv;
      xv  = 8'(v);
      inv = 8'h00;
      if (xv != 8'h00) begin
        inv = 8'h01;
        for (int j = 0; j < 254; j++) inv = gm(inv, xv);
      end
      sbox[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  end

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   k [16];
    logic [7:0]   t [16];
    logic [7:0]   tw [4];
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    for (int r = 1; r <= 10; r++) begin
      tw[0] = sbox[k[13]] ^ rc;
      tw[1] = sbox[k[14]];
      tw[2] = sbox[k[15]];
      tw[3] = sbox[k[12]];
      for (int i = 0; i < 4; i++) k[i] = k[i] ^ tw[i];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) t[rw+4*c] = s[rw + 4*((c+rw)%4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Stand-in aes_128: result captured by the DUT LAT edges after aes_state loads
  always @(posedge clk) begin
    pipe[0] <= aes_enc(aes_state, aes_key);
    for (int j = 1; j < LAT-1; j++) pipe[j] <= pipe[j-1];
  end
  assign aes_out = pipe[LAT-2];

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard push: every accepted job queues its expected response
  always @(negedge clk) begin : pusher
    exp_t e;
    #2;
    if (rst_n) begin
      chk("ready_onehot", 128'(req0_ready & req1_ready), 128'(0));
      if (req0_valid && req0_ready) begin
        e.data = aes_enc(req0_state, req0_key);
        e.id   = 1'b0;
        exp_q.push_back(e);
        glog.push_back(0);
        n_issued++;
      end
      if (req1_valid && req1_ready) begin
        e.data = aes_enc(req1_state, req1_key);
        e.id   = 1'b1;
        exp_q.push_back(e);
        glog.push_back(1);
        n_issued++;
      end
    end
  end

  // Monitor: compare each popped response against the queue head
  always @(negedge clk) begin : monitor
    exp_t e;
    #2;
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_rsp actual data=%h id=%0d required no response", rsp_data, rsp_id);
      end else if (rsp_ready) begin
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_id", 128'(rsp_id), 128'(e.id));
      end
    end
  end

  // Reset discards every outstanding job
  always @(negedge rst_n) exp_q.delete();

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #3;
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    chk("drain_idle", 128'(done), 128'(1));
  endtask

  task automatic run_single(input logic [127:0] st, input logic [127:0] key,
                            input bit chk_ct, input logic [127:0] ct);
    int k;
    bit got = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1;
    req0_state = st;
    req0_key   = key;
    #3;
    chk("single_issue_ready", 128'(req0_ready), 128'(1));
    k = cyc;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      #3;
      if (rsp_valid) got = 1'b1;
    end
    chk("single_got_rsp", 128'(got), 128'(1));
    chk("single_latency", 128'(cyc), 128'(k + 22));
    if (chk_ct) chk("fips_ciphertext", rsp_data, ct);
    chk("single_rsp_id", 128'(rsp_id), 128'(0));
    chk("single_busy_high", 128'(busy), 128'(1));
    @(negedge clk);
    #3;
    chk("single_busy_low", 128'(busy), 128'(0));
    chk("single_rsp_valid_low", 128'(rsp_valid), 128'(0));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin : main
    int k;
    int cnt;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_state = '0;   req0_key   = '0;
    req1_state = '0;   req1_key   = '0;
    rsp_ready  = 1'b1;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_aes_state", aes_state, 128'(0));
    chk("reset_aes_key", aes_key, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 single job
    run_single(FIPS_PT, FIPS_KEY, 1'b1, FIPS_CT);

    // Lone req1 while the RR pointer names req0
    do_reset();
    glog.delete();
    @(negedge clk);
    req1_valid = 1'b1;
    req1_state = 128'hdeadbeef_00000000_cafef00d_12345678;
    req1_key   = KEY_B;
    #3;
    chk("lone_req1_ready", 128'(req1_ready), 128'(1));
    chk("lone_req0_ready", 128'(req0_ready), 128'(0));
    @(negedge clk);
    req1_valid = 1'b0;
    wait_idle(60);
    chk("lone_grants", 128'(glog.size()), 128'(1));
    chk("lone_grant_id", 128'(glog[0]), 128'(1));

    // Both requesters valid for 8 cycles: strict alternation from req0
    do_reset();
    glog.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_state = FIPS_PT ^ 128'(i);
      req0_key   = FIPS_KEY;
      req1_state = 128'h3243f6a8885a308d313198a2e0370734 ^ 128'(i << 8);
      req1_key   = KEY_B;
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle(80);
    chk("rr_grant_count", 128'(glog.size()), 128'(8));
    for (int i = 0; i < 8; i++) chk("rr_grant_order", 128'(glog[i]), 128'(i % 2));

    // Credit exhaustion under back-pressure, then pop+issue at full credits
    do_reset();
    rsp_ready = 1'b0;
    n_issued  = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      req0_valid = 1'b1;
      req0_state = 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0 ^ 128'(i);
      req0_key   = KEY_B;
    end
    #3;
    chk("credit_issue_count", 128'(n_issued), 128'(32));
    chk("credit_full_ready", 128'(req0_ready), 128'(0));
    @(negedge clk);
    rsp_ready  = 1'b1;
    req0_state = 128'h0123456789abcdef_fedcba9876543210;
    #3;
    chk("pop_frees_slot_ready", 128'(req0_ready), 128'(1));
    @(negedge clk);
    rsp_ready = 1'b0;
    #3;
    chk("credits_stay_full", 128'(req0_ready), 128'(0));
    chk("credit_issue_count_after", 128'(n_issued), 128'(33));
    @(negedge clk);
    req0_valid = 1'b0;
    rsp_ready  = 1'b1;
    cnt = 0;
    for (int i = 0; i < 31; i++) begin
      #3;
      if (rsp_valid) cnt++;
      @(negedge clk);
    end
    chk("drain_one_per_cycle", 128'(cnt), 128'(31));
    wait_idle(80);

    // Reset in the middle of a 5-job burst
    do_reset();
    rsp_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req0_valid = 1'b1;
      req0_state = 128'h11111111_22222222_33333333_44444444 ^ 128'(i);
      req0_key   = FIPS_KEY;
      if (i == 0) begin
        #3;
        k = cyc;
      end
    end
    @(negedge clk);
    req0_valid = 1'b0;
    while (cyc < k + 11) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_aes_state", aes_state, 128'(0));
    chk("midrst_aes_key", aes_key, 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #3;
      if (rsp_valid) cnt++;
    end
    chk("midrst_no_rsp", 128'(cnt), 128'(0));
    run_single(128'hffeeddccbbaa99887766554433221100, KEY_B, 1'b0, 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_128_sched.md
Name: aes_128_sched

Overview:
- Round-robin scheduler that shares one aes_128 pipeline between two requesters.
- aes_128 cannot stall, so every issue first reserves space in an internal output FIFO (credits); results are never dropped.
- Tracks in-flight jobs with a LATENCY-deep valid/ID shift register and returns ciphertexts in issue order, tagged with requester ID.
- Sits between the encryption clients (LFSR stimulus sources in benches) and the aes_128 instance.

Parameters:
- LATENCY, 21, edges from the edge that loads aes_state/aes_key to the edge that captures the matching aes_out
- FIFO_DEPTH, 32, output FIFO entries; must be a power of two and >= 2

Ports:
- clk  in  1  single clock; also drives aes_128
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a job
- req0_ready  out  1  requester 0 job accepted this cycle
- req0_state  in  128  requester 0 plaintext
- req0_key  in  128  requester 0 key
- req1_valid, req1_ready, req1_state, req1_key  in/out/in/in  1/1/128/128  same as requester 0
- aes_state  out  128  registered plaintext to aes_128.state
- aes_key  out  128  registered key to aes_128.key
- aes_out  in  128  aes_128.out
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer accepts head
- rsp_data  out  128  ciphertext at FIFO head (first-word fall-through)
- rsp_id  out  1  requester ID of head
- busy  out  1  any job in flight or in FIFO

Behaviour:
- Reset (async assert, sync release): aes_state = 0, aes_key = 0, in-flight shift register cleared, FIFO empty, credit count = 0, RR pointer = 0, rsp_valid = 0, busy = 0.
- credits = in-flight jobs + FIFO occupancy, range 0..FIFO_DEPTH.
- can_issue = (credits < FIFO_DEPTH) || (rsp_valid && rsp_ready). A same-cycle pop frees a slot.
- Arbitration (combinational):
  - Only one requester valid: that one wins.
  - Both valid: the one the RR pointer names wins.
  - reqX_ready = winner && can_issue. Readies are never both high.
  - ready may depend on valid; valid must not wait for ready.
- Issue, on an edge with reqX_valid && reqX_ready:
  - aes_state/aes_key load reqX_state/reqX_key.
  - Shift-register stage 0 loads {1, X}.
  - RR pointer becomes ~X.
- Non-issue edge: stage 0 loads {0, –}; aes_state/aes_key hold their values. RR pointer changes only on issue.
- Shift register advances every edge. A job issued on edge N reaches the tail and aes_out is captured into the FIFO, with its ID, on edge N+LATENCY.
- Credits:
  - +1 on issue, −1 on pop (rsp_valid && rsp_ready), unchanged when both occur.
  - The capture moves an entry from in-flight to the FIFO and does not change credits.
  - The FIFO can never overflow; an overflow is an assertion failure.
- Back-to-back issue every cycle sustains 1 job/clk while rsp_ready = 1.
- Ordering: responses leave in exact issue order, both IDs interleaved.
- FIFO wrap-around uses log2(FIFO_DEPTH)+1-bit pointers; full/empty follow from the extra bit.
- Simultaneous capture and pop when FIFO is empty: the captured entry appears on rsp_* the next cycle. No bypass; rsp_valid is registered from FIFO state.
- busy = credits != 0.
- Reset mid-operation discards all in-flight and buffered jobs. aes_128 internal state is not reset, but its outputs are ignored because the shift register is cleared.

Test Plan:
- FIPS-197: req0 key 000102030405060708090a0b0c0d0e0f, state 00112233445566778899aabbccddeeff issued at edge N, rsp_ready = 1 -> rsp_valid rises after edge N+21 with rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id 0; busy low one cycle after pop.
- Both requesters valid continuously for 8 cycles from reset -> grants 0,1,0,1,0,1,0,1; 8 responses in that ID order, each matching a software AES model.
- rsp_ready = 0, req0 valid continuously -> exactly 32 issues, then req0_ready = 0 with credits = 32. rsp_ready = 1 -> one pop per cycle, and req0_ready reasserts in the first pop cycle.
- At credits = 32, pop and request in the same cycle -> issue accepted, credits stays 32, no FIFO overflow.
- rst_n pulsed low at edge N+10 of a 5-job burst -> all outputs return to reset values immediately; no rsp_valid ever for those jobs. A new job after release completes normally at +21.
- Only req1 valid while RR pointer = 0 -> req1 granted at once, with no idle cycle.
